pipelined_add_sub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor built from segmented ripple-carry stages, with a registered carry between segments. It accepts one operation per cycle through a valid/ready handshake. It produces sum/difference plus carry, signed-overflow and zero flags, and has an optional signed-saturation mode. It replaces the purely combinational ripple adder/subtractor on datapaths whose width would otherwise break timing.

---
 rtl/pipelined_add_sub.sv | 138 +++++++++++++
 tb/tb_pipelined_add_sub.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// Segmented ripple-carry adder/subtractor: one SEG-bit slice per pipeline stage,
// carry registered between slices, valid/ready flow control with a global stall.
module pipelined_add_sub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int NSEG = WIDTH / SEG;

  if ((WIDTH < 2) || (SEG < 1) || ((WIDTH % SEG) != 0)) begin : g_param_check
    $error("pipelined_add_sub: WIDTH must be >= 2 and a multiple of SEG");
  end

  logic             v_q   [NSEG];
  logic             v_d   [NSEG];
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] a_d   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] b_d   [NSEG];
  logic [WIDTH-1:0] r_q   [NSEG];
  logic [WIDTH-1:0] r_d   [NSEG];
  logic             cy_q  [NSEG];
  logic             cy_d  [NSEG];
  logic             sat_q [NSEG];
  logic             sat_d [NSEG];
  logic             ovf_q;
  logic             ovf_d;
  logic             zero_q;
  logic             zero_d;

  logic             st_v_s   [NSEG];
  logic [WIDTH-1:0] st_a_s   [NSEG];
  logic [WIDTH-1:0] st_b_s   [NSEG];
  logic [WIDTH-1:0] st_r_s   [NSEG];
  logic             st_c_s   [NSEG];
  logic             st_sat_s [NSEG];

  logic [SEG:0]     seg_sum_s;
  logic [WIDTH-1:0] raw_res_s;
  logic [WIDTH-1:0] sat_res_s;
  logic             msb_cin_s;
  logic             adv_s;

  // A full output that is not being taken freezes every stage at once.
  assign adv_s     = !v_q[NSEG-1] || out_ready;
  assign in_ready  = adv_s;
  assign out_valid = v_q[NSEG-1];
  assign result    = r_q[NSEG-1];
  assign carry     = cy_q[NSEG-1];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  // Stage inputs: stage 0 sees the port (B pre-inverted for subtract), later stages the previous registers.
  always_comb begin
    st_v_s[0]   = in_valid;
    st_a_s[0]   = a;
    st_b_s[0]   = b ^ {WIDTH{sub}};
    st_r_s[0]   = {WIDTH{1'b0}};
    st_c_s[0]   = sub;
    st_sat_s[0] = sat;
    for (int k = 1; k < NSEG; k++) begin
      st_v_s[k]   = v_q[k-1];
      st_a_s[k]   = a_q[k-1];
      st_b_s[k]   = b_q[k-1];
      st_r_s[k]   = r_q[k-1];
      st_c_s[k]   = cy_q[k-1];
      st_sat_s[k] = sat_q[k-1];
    end
  end

  // Per-stage slice add, plus flag and saturation logic folded into the last stage.
  always_comb begin
    seg_sum_s = {(SEG+1){1'b0}};
    for (int k = 0; k < NSEG; k++) begin
      seg_sum_s = {1'b0, st_a_s[k][k*SEG +: SEG]}
                + {1'b0, st_b_s[k][k*SEG +: SEG]}
                + {{SEG{1'b0}}, st_c_s[k]};
      v_d[k]   = st_v_s[k];
      a_d[k]   = st_a_s[k];
      b_d[k]   = st_b_s[k];
      sat_d[k] = st_sat_s[k];
      cy_d[k]  = seg_sum_s[SEG];
      r_d[k]   = st_r_s[k];
      r_d[k][k*SEG +: SEG] = seg_sum_s[SEG-1:0];
    end
    raw_res_s = r_d[NSEG-1];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB can be recovered from it.
    msb_cin_s = raw_res_s[WIDTH-1] ^ st_a_s[NSEG-1][WIDTH-1] ^ st_b_s[NSEG-1][WIDTH-1];
    ovf_d     = msb_cin_s ^ cy_d[NSEG-1];
    sat_res_s = raw_res_s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                   : {1'b1, {(WIDTH-1){1'b0}}};
    r_d[NSEG-1] = (st_sat_s[NSEG-1] && ovf_d) ? sat_res_s : raw_res_s;
    zero_d      = (r_d[NSEG-1] == {WIDTH{1'b0}});
  end

  // Pipeline registers; all stages load together on advance and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= {WIDTH{1'b0}};
        b_q[k]   <= {WIDTH{1'b0}};
        r_q[k]   <= {WIDTH{1'b0}};
        cy_q[k]  <= 1'b0;
        sat_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv_s) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k]   <= v_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        r_q[k]   <= r_d[k];
        cy_q[k]  <= cy_d[k];
        sat_q[k] <= sat_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: 16/4 main instance plus 8/8 and 8/1 variants.
module tb_pipelined_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic        iv16, ir16, sub16, sat16, ov16, ordy16, c16, o16, z16;
  logic [15:0] a16, b16, r16;

  logic        iv8, sub8, sat8, ordy8;
  logic [7:0]  a8, b8;
  logic        ir8a, ov8a, c8a, o8a, z8a;
  logic [7:0]  r8a;
  logic        ir8b, ov8b, c8b, o8b, z8b;
  logic [7:0]  r8b;

  pipelined_add_sub #(.WIDTH(16), .SEG(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .sub(sub16), .sat(sat16), .out_valid(ov16), .out_ready(ordy16), .result(r16),
    .carry(c16), .overflow(o16), .zero(z16));

  pipelined_add_sub #(.WIDTH(8), .SEG(8)) u8a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8a), .a(a8), .b(b8),
    .sub(sub8), .sat(sat8), .out_valid(ov8a), .out_ready(ordy8), .result(r8a),
    .carry(c8a), .overflow(o8a), .zero(z8a));

  pipelined_add_sub #(.WIDTH(8), .SEG(1)) u8b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8b), .a(a8), .b(b8),
    .sub(sub8), .sat(sat8), .out_valid(ov8b), .out_ready(ordy8), .result(r8b),
    .carry(c8b), .overflow(o8b), .zero(z8b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent model: 17-bit add or subtract, borrow-based carry, sign-rule overflow.
  function automatic logic [18:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input logic st);
    logic [16:0] full;
    logic [15:0] r;
    logic        c, o;
    full = s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    r    = full[15:0];
    c    = s ? !full[16] : full[16];
    o    = s ? ((x[15] != y[15]) && (r[15] != x[15])) : ((x[15] == y[15]) && (r[15] != x[15]));
    if (st && o) r = r[15] ? 16'h7FFF : 16'h8000;
    return {r, c, o, (r == 16'h0000)};
  endfunction

  task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                       input logic ts, input logic tsat, input logic [15:0] er,
                       input logic ec, input logic eo, input logic ez);
    int lat;
    @(negedge clk);
    a16 = ta; b16 = tb; sub16 = ts; sat16 = tsat; iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    lat  = 1;
    while (!ov16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd4);
    chk({tag, " result"}, 32'(r16), 32'(er));
    chk({tag, " flags"}, 32'({c16, o16, z16}), 32'({ec, eo, ez}));
  endtask

  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input logic ts, input logic tsat, input logic [10:0] exp);
    int n, la, lb;
    logic [10:0] pa, pb;
    @(negedge clk);
    a8 = ta; b8 = tb; sub8 = ts; sat8 = tsat; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    n = 1; la = 0; lb = 0; pa = 11'h0; pb = 11'h0;
    while ((la == 0 || lb == 0) && n < 20) begin
      if (ov8a && la == 0) begin la = n; pa = {r8a, c8a, o8a, z8a}; end
      if (ov8b && lb == 0) begin lb = n; pb = {r8b, c8b, o8b, z8b}; end
      if (la == 0 || lb == 0) begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, " seg8 latency"}, 32'(la), 32'd1);
    chk({tag, " seg8 out"}, 32'(pa), 32'(exp));
    chk({tag, " seg1 latency"}, 32'(lb), 32'd8);
    chk({tag, " seg1 out"}, 32'(pb), 32'(exp));
  endtask

  logic [15:0] sa [32];
  logic [15:0] sb [32];
  logic        ss [32];
  logic        st [32];
  logic [15:0] pa [4];
  logic [15:0] pb [4];

  initial begin
    int first, last, nout;
    rst_n = 1'b0;
    iv16 = 1'b0; a16 = 16'h0; b16 = 16'h0; sub16 = 1'b0; sat16 = 1'b0; ordy16 = 1'b1;
    iv8 = 1'b0; a8 = 8'h0; b8 = 8'h0; sub8 = 1'b0; sat8 = 1'b0; ordy8 = 1'b1;

    #12;
    chk("reset out_valid", 32'(ov16), 32'd0);
    chk("reset result", 32'(r16), 32'd0);
    chk("reset flags", 32'({c16, o16, z16}), 32'd0);
    chk("reset in_ready", 32'(ir16), 32'd1);
    chk("reset valid8", 32'({ov8a, ov8b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset in_ready", 32'(ir16), 32'd1);

    run16("pos ovf wrap", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run16("pos ovf sat",  16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run16("sub borrow",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run16("neg ovf sat",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
    run16("sub equal",    16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run16("add wrap zero",16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run16("min+min sat",  16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
    run16("min+neg1",     16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    run8("8 pos ovf",  8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1, 1'b0});
    run8("8 wrap zero",8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1});
    run8("8 borrow",   8'h05, 8'h07, 1'b1, 1'b0, {8'hFE, 1'b0, 1'b0, 1'b0});
    run8("8 neg sat",  8'h80, 8'h01, 1'b1, 1'b1, {8'h80, 1'b1, 1'b1, 1'b0});
    run8("8 plain",    8'h12, 8'h34, 1'b0, 1'b0, {8'h46, 1'b0, 1'b0, 1'b0});

    // Back-to-back random stream.
    for (int i = 0; i < 32; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
      ss[i] = 1'($urandom_range(0, 1));
      st[i] = 1'($urandom_range(0, 1));
    end
    first = -1; last = -1; nout = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (ov16) begin
        if (first < 0) first = cyc;
        last = cyc;
        if (nout < 32)
          chk($sformatf("stream beat %0d", nout), 32'({r16, c16, o16, z16}),
              32'(ref16(sa[nout], sb[nout], ss[nout], st[nout])));
        nout++;
      end
      if (cyc < 32) begin
        a16 = sa[cyc]; b16 = sb[cyc]; sub16 = ss[cyc]; sat16 = st[cyc]; iv16 = 1'b1;
      end else begin
        iv16 = 1'b0;
      end
    end
    chk("stream first latency", 32'(first), 32'd4);
    chk("stream count", 32'(nout), 32'd32);
    chk("stream contiguous", 32'(last - first), 32'd31);

    // Backpressure: fill, stall 10 cycles with a beat offered, then drain.
    pa[0] = 16'h1111; pb[0] = 16'h0222;
    pa[1] = 16'h7000; pb[1] = 16'h1000;
    pa[2] = 16'h0100; pb[2] = 16'h0200;
    pa[3] = 16'hABCD; pb[3] = 16'hABCD;
    @(negedge clk);
    ordy16 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a16 = pa[i]; b16 = pb[i]; sub16 = (i == 3); sat16 = 1'b0; iv16 = 1'b1;
      @(negedge clk);
    end
    a16 = 16'h5555; b16 = 16'h1111; sub16 = 1'b0; sat16 = 1'b0; iv16 = 1'b1;
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("stall %0d ready/valid", j), 32'({ir16, ov16}), 32'({1'b0, 1'b1}));
      chk($sformatf("stall %0d hold", j), 32'({r16, c16, o16, z16}),
          32'(ref16(pa[0], pb[0], 1'b0, 1'b0)));
      @(negedge clk);
    end
    iv16 = 1'b0;
    ordy16 = 1'b1;
    nout = 1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (ov16) begin
        if (nout < 4)
          chk($sformatf("drain beat %0d", nout), 32'({r16, c16, o16, z16}),
              32'(ref16(pa[nout], pb[nout], (nout == 3), 1'b0)));
        nout++;
      end
    end
    chk("drain count", 32'(nout), 32'd4);

    // Asynchronous reset with beats in flight.
    for (int i = 0; i < 4; i++) begin
      a16 = (i == 0) ? 16'h7FFF : 16'h0101; b16 = 16'h0001; sub16 = 1'b0; sat16 = 1'b0;
      iv16 = 1'b1;
      @(negedge clk);
    end
    iv16 = 1'b0;
    chk("pre-reset output", 32'({ov16, r16, o16}), 32'({1'b1, 16'h8000, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", 32'(ov16), 32'd0);
    chk("mid reset outputs", 32'({r16, c16, o16, z16}), 32'd0);
    chk("mid reset in_ready", 32'(ir16), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    nout = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (ov16) nout++;
    end
    chk("discarded beats", 32'(nout), 32'd0);
    run16("after reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
